wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback unit directly upstream of the integer register file; drives its single write port (wen/waddr/wdata).
- Accepts one retiring instruction at a time from the execute stage over a valid/ready handshake.
- ALU results are written back directly. Loads issue one memory read, wait for the response, extract and extend the addressed byte, half or word, then write back.
- Emits a one-cycle commit pulse per retired instruction for the simulation harness.

Parameters:
- ADDR_WIDTH, 5, register index width; must match the register file.
- DATA_WIDTH, 32, datapath width; load extraction is defined for 32 only.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  stage can accept; high only in IDLE
- in_rd  in  ADDR_WIDTH  destination register index
- in_rd_wen  in  1  instruction writes rd
- in_result  in  DATA_WIDTH  ALU result, or effective address when in_is_load=1
- in_is_load  in  1  instruction is a load
- in_ld_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- in_ld_unsigned  in  1  zero-extend (1) or sign-extend (0)
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}
- mem_rsp_valid  in  1  read data valid
- mem_rsp_data  in  DATA_WIDTH  full aligned word
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write index
- rf_wdata  out  DATA_WIDTH  register file write data
- commit  out  1  one-cycle pulse per retired instruction
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State forced to IDLE; all internal registers cleared.
  - rf_wen, rf_waddr, rf_wdata, mem_req_valid, mem_req_addr, commit and busy are all 0.
  - in_ready=1 (decoded from IDLE).
- State machine has four states: IDLE, REQ, RESP, WB.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture all in_* fields.
  - Next state is REQ if in_is_load=1, otherwise WB.
- REQ:
  - mem_req_valid=1; mem_req_addr is held stable from captured address.
  - On mem_req_ready=1, go to RESP.
  - mem_rsp_valid is ignored in this state.
- RESP:
  - Wait for mem_rsp_valid; any number of cycles is allowed.
  - On mem_rsp_valid, extract using captured address bits:
    - byte: lane addr[1:0] (lane 0 = bits 7:0).
    - half: addr[1] selects bits 15:0 or 31:16; addr[0] ignored.
    - word: whole word.
  - Extend per in_ld_unsigned; store as result; go to WB.
- WB (exactly one cycle):
  - commit=1.
  - rf_wen=1 only if rd_wen=1 and rd!=0; rf_waddr=rd, rf_wdata=result.
  - Next state IDLE.
- Output timing: rf_wen, rf_waddr, rf_wdata and commit are decoded from WB state and captured registers, with no combinational path from in_*. rf_waddr and rf_wdata hold their last values outside WB.
- Latency:
  - Non-load accepted at edge N: writeback/commit in cycle N+1, in_ready again in N+2.
  - Load: 1 (REQ) + request wait + response wait + 1 (WB) cycles minimum.
- Back-to-back throughput: at most one instruction every 2 cycles; no overlap.
- rd==0 or rd_wen=0: commit still pulses, rf_wen stays 0.
- mem_rsp_valid outside RESP is dropped, with no state change.
- Reset during REQ or RESP: the load is abandoned and mem_req_valid drops immediately. A late response after reset is ignored.

Optional Feature:
- Macro WB_STAGE_PERF_EN.
- When defined, adds outputs:
  - perf_instret [63:0]: increments on every commit.
  - perf_mem_stall [31:0]: increments every cycle in REQ or RESP; wraps at 2^32.
  - Both reset to 0.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then non-load in_rd=5, in_result=0x1234_5678 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, commit=1; in_ready low that cycle.
- Non-load in_rd=0, in_rd_wen=1, in_result=0xFFFF_FFFF -> commit=1, rf_wen=0.
- Signed byte load, addr 0x8000_0003, rsp 0x80FF_0011 -> mem_req_addr=0x8000_0000, rf_wdata=0xFFFF_FF80; same with unsigned -> 0x0000_0080.
- Half load, addr 0x8000_0002, unsigned=0, rsp 0x8001_7FFF -> rf_wdata=0xFFFF_8001; addr 0x8000_0000 -> 0x0000_7FFF.
- Stalls: mem_req_ready low 3 cycles, then rsp 4 cycles later; spurious mem_rsp_valid during REQ -> ignored, mem_req_addr stable, exactly one commit, correct data.
- Assert rst_n=0 in RESP -> mem_req_valid and busy 0 immediately; rsp after release -> no rf_wen, no commit. With WB_STAGE_PERF_EN, perf_instret reads 0.

Source files
------------

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: retires ALU results and byte/half/word loads into the register file.
// Optional performance counters are built in when WB_STAGE_PERF_EN is defined.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit,
  output logic                  busy
`ifdef WB_STAGE_PERF_EN
  ,
  output logic [63:0]           perf_instret,
  output logic [31:0]           perf_mem_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   rd_q;
  logic                    rd_wen_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic                    rf_wen_q;
  logic [ADDR_WIDTH-1:0]   rf_waddr_q;
  logic [DATA_WIDTH-1:0]   rf_wdata_q;
  logic                    commit_q;

  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_d;

  // result_q holds the effective address while a load is in flight.
  always_comb begin
    byte_sel = 8'd0;
    half_sel = 16'd0;
    load_d   = mem_rsp_data;
    case (result_q[1:0])
      2'b00:   byte_sel = mem_rsp_data[7:0];
      2'b01:   byte_sel = mem_rsp_data[15:8];
      2'b10:   byte_sel = mem_rsp_data[23:16];
      default: byte_sel = mem_rsp_data[31:24];
    endcase
    half_sel = result_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (size_q)
      2'b00:   load_d = {{(DATA_WIDTH-8){~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_d = {{(DATA_WIDTH-16){~uns_q & half_sel[15]}}, half_sel};
      default: load_d = mem_rsp_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      result_q   <= '0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      commit_q   <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      rf_wen_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rd_q     <= in_rd;
            rd_wen_q <= in_rd_wen;
            result_q <= in_result;
            size_q   <= in_ld_size;
            uns_q    <= in_ld_unsigned;
            if (in_is_load) begin
              state_q <= S_REQ;
            end else begin
              state_q    <= S_WB;
              commit_q   <= 1'b1;
              rf_wen_q   <= in_rd_wen && (in_rd != '0);
              rf_waddr_q <= in_rd;
              rf_wdata_q <= in_result;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) state_q <= S_RESP;
        end
        S_RESP: begin
          if (mem_rsp_valid) begin
            state_q    <= S_WB;
            commit_q   <= 1'b1;
            rf_wen_q   <= rd_wen_q && (rd_q != '0);
            rf_waddr_q <= rd_q;
            rf_wdata_q <= load_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = {result_q[DATA_WIDTH-1:2], 2'b00};
  assign rf_wen        = rf_wen_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign commit        = commit_q;

`ifdef WB_STAGE_PERF_EN
  logic [63:0] instret_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= 64'd0;
      stall_q   <= 32'd0;
    end else begin
      if (commit_q) instret_q <= instret_q + 64'd1;
      if (state_q == S_REQ || state_q == S_RESP) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_instret   = instret_q;
  assign perf_mem_stall = stall_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed and randomized checks of wb_stage against a behavioural load/writeback model.
// Perf counter checks are included when WB_STAGE_PERF_EN is defined.
module tb_wb_stage;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rd;
  logic          in_rd_wen;
  logic [DW-1:0] in_result;
  logic          in_is_load;
  logic [1:0]    in_ld_size;
  logic          in_ld_unsigned;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [DW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          commit;
  logic          busy;
`ifdef WB_STAGE_PERF_EN
  logic [63:0]   perf_instret;
  logic [31:0]   perf_mem_stall;
`endif

  wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_result(in_result), .in_is_load(in_is_load), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit(commit), .busy(busy)
`ifdef WB_STAGE_PERF_EN
    , .perf_instret(perf_instret), .perf_mem_stall(perf_mem_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int commits  = 0;
  int busy_nc  = 0;
  int exp_instret = 0;
  int exp_stall   = 0;

  // Observe each cycle shortly after the rising edge.
  always @(posedge clk) begin
    #2;
    if (commit === 1'b1) commits++;
    if (busy === 1'b1 && commit !== 1'b1) busy_nc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load semantics from first principles: shift the addressed bytes down, mask, optionally sign-extend.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz,
                                          input logic uns, input logic [31:0] word);
    int nb;
    int off;
    logic [63:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = (sz == 2'd0) ? int'(addr % 4) : (sz == 2'd1) ? int'((addr / 2) % 2) * 2 : 0;
    v = ({32'd0, word} >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
    if (!uns && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  task automatic send(input logic [4:0] rd, input logic wen, input logic [31:0] res,
                      input logic ld, input logic [1:0] sz, input logic uns);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_rd = rd; in_rd_wen = wen; in_result = res;
    in_is_load = ld; in_ld_size = sz; in_ld_unsigned = uns;
    @(negedge clk);
    in_valid = 1'b0; in_rd = $urandom; in_result = $urandom; in_is_load = $urandom;
  endtask

  task automatic run_alu(input logic [4:0] rd, input logic wen, input logic [31:0] res);
    int c0;
    c0 = commits;
    send(rd, wen, res, 1'b0, 2'd0, 1'b0);
    check("alu_commit", commit, 1);
    check("alu_rf_wen", rf_wen, (wen && rd != 0) ? 1 : 0);
    check("alu_rf_waddr", rf_waddr, rd);
    check("alu_rf_wdata", rf_wdata, res);
    check("alu_in_ready_wb", in_ready, 0);
    check("alu_busy_wb", busy, 1);
    @(negedge clk);
    check("alu_commit_drop", commit, 0);
    check("alu_rf_wen_drop", rf_wen, 0);
    check("alu_in_ready_back", in_ready, 1);
    check("alu_wdata_hold", rf_wdata, res);
    check("alu_one_commit", commits, c0 + 1);
    exp_instret++;
  endtask

  task automatic run_load(input logic [4:0] rd, input logic wen, input logic [31:0] addr,
                          input logic [1:0] sz, input logic uns, input logic [31:0] word,
                          input logic [31:0] exp, input int req_stall, input int rsp_wait,
                          input bit spurious);
    int c0;
    c0 = commits;
    send(rd, wen, addr, 1'b1, sz, uns);
    for (int i = 0; i < req_stall; i++) begin
      check("req_valid", mem_req_valid, 1);
      check("req_addr", mem_req_addr, {addr[31:2], 2'b00});
      check("req_no_commit", commit, 0);
      if (spurious) begin mem_rsp_valid = 1'b1; mem_rsp_data = $urandom; end
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    check("req_valid", mem_req_valid, 1);
    check("req_addr", mem_req_addr, {addr[31:2], 2'b00});
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      check("resp_req_low", mem_req_valid, 0);
      check("resp_busy", busy, 1);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = word;
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
    check("ld_commit", commit, 1);
    check("ld_rf_wen", rf_wen, (wen && rd != 0) ? 1 : 0);
    check("ld_rf_waddr", rf_waddr, rd);
    check("ld_rf_wdata", rf_wdata, exp);
    @(negedge clk);
    check("ld_commit_drop", commit, 0);
    check("ld_in_ready_back", in_ready, 1);
    check("ld_one_commit", commits, c0 + 1);
    exp_instret++;
    exp_stall += req_stall + 1 + rsp_wait + 1;
  endtask

  task automatic reset_mid_load(input bit in_resp);
    int c0;
    send(5'd7, 1'b1, 32'h4000_0010, 1'b1, 2'd2, 1'b0);
    if (in_resp) begin
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("rst_pre_busy", busy, 1);
    end else begin
      check("rst_pre_req_valid", mem_req_valid, 1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
`ifdef WB_STAGE_PERF_EN
    check("rst_perf_instret", perf_instret, 0);
    check("rst_perf_stall", perf_mem_stall, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    c0 = commits;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_rsp_no_wen", rf_wen, 0);
      check("late_rsp_no_commit", commit, 0);
      @(negedge clk);
    end
    check("late_rsp_commit_count", commits, c0);
    check("late_rsp_idle", busy, 0);
  endtask

  initial begin
    logic [4:0]  r_rd;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [1:0]  r_sz;
    logic        r_uns;
    logic [31:0] r_word;

    rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_result = '0;
    in_is_load = 1'b0; in_ld_size = 2'd0; in_ld_unsigned = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rf_wen", rf_wen, 0);
    check("reset_rf_waddr", rf_waddr, 0);
    check("reset_rf_wdata", rf_wdata, 0);
    check("reset_commit", commit, 0);
    check("reset_req_valid", mem_req_valid, 0);
    check("reset_req_addr", mem_req_addr, 0);
    rst_n = 1'b1;
    commits = 0;
    busy_nc = 0;

    run_alu(5'd5, 1'b1, 32'h1234_5678);
    run_alu(5'd0, 1'b1, 32'hFFFF_FFFF);
    run_alu(5'd9, 1'b0, 32'hA5A5_0F0F);

    run_load(5'd3, 1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_0011, 32'hFFFF_FF80, 0, 0, 0);
    run_load(5'd3, 1'b1, 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_0011, 32'h0000_0080, 0, 0, 0);
    run_load(5'd4, 1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001, 1, 1, 0);
    run_load(5'd4, 1'b1, 32'h8000_0000, 2'd1, 1'b0, 32'h8001_7FFF, 32'h0000_7FFF, 0, 2, 0);
    run_load(5'd6, 1'b1, 32'h1000_0105, 2'd2, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 4, 1);
    run_load(5'd8, 1'b1, 32'h1000_0002, 2'd3, 1'b0, 32'h8765_4321, 32'h8765_4321, 0, 1, 0);
    run_load(5'd0, 1'b1, 32'h1000_0001, 2'd0, 1'b0, 32'h0000_FF00, 32'hFFFF_FFFF, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      r_rd = $urandom; r_wen = $urandom; r_addr = $urandom; r_sz = $urandom;
      r_uns = $urandom; r_word = $urandom;
      if ($urandom_range(0, 2) == 0)
        run_alu(r_rd, r_wen, r_addr);
      else
        run_load(r_rd, r_wen, r_addr, r_sz, r_uns, r_word, ref_load(r_addr, r_sz, r_uns, r_word),
                 $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 1) == 1);
    end

    check("total_commits", commits, exp_instret);
    check("mem_busy_cycles", busy_nc, exp_stall);
`ifdef WB_STAGE_PERF_EN
    check("perf_instret", perf_instret, exp_instret);
    check("perf_mem_stall", perf_mem_stall, exp_stall);
`endif

    reset_mid_load(1'b0);
    reset_mid_load(1'b1);
    run_alu(5'd1, 1'b1, 32'h0BAD_CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
